// File: rtl/i2c_line_filter.sv
// I2C pad front end: two-flop synchronisers, per-line persistence filters,
// SCL edge and START/STOP strobes, and a saturating rejected-glitch counter.
module i2c_line_filter #(
   parameter int FILTER_CYCLES = 4,
   parameter int GCNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   input  logic              glitch_clr,
   output logic              scl_filt,
   output logic              sda_filt,
   output logic              scl_rise,
   output logic              scl_fall,
   output logic              start_det,
   output logic              stop_det,
   output logic [GCNT_W-1:0] glitch_cnt
);

   localparam logic [3:0]      CNT_LAST  = 4'(FILTER_CYCLES - 1);
   localparam logic [GCNT_W:0] GCNT_MAX  = {1'b0, {GCNT_W{1'b1}}};
   localparam logic [GCNT_W:0] GCNT_ZERO = {(GCNT_W+1){1'b0}};

   logic              scl_meta_q, scl_meta_d;
   logic              scl_sync_q, scl_sync_d;
   logic              sda_meta_q, sda_meta_d;
   logic              sda_sync_q, sda_sync_d;
   logic              scl_filt_q, scl_filt_d;
   logic              sda_filt_q, sda_filt_d;
   logic              scl_prev_q, scl_prev_d;
   logic              sda_prev_q, sda_prev_d;
   logic [3:0]        scl_cnt_q, scl_cnt_d;
   logic [3:0]        sda_cnt_q, sda_cnt_d;
   logic [GCNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
   logic              scl_glitch_s;
   logic              sda_glitch_s;
   logic [GCNT_W:0]   glitch_sum_s;

   // Synchroniser chains and one-cycle-delayed copies of the filtered levels.
   always_comb begin
      scl_meta_d = scl_in;
      scl_sync_d = scl_meta_q;
      sda_meta_d = sda_in;
      sda_sync_d = sda_meta_q;
      scl_prev_d = scl_filt_q;
      sda_prev_d = sda_filt_q;
   end

   // SCL persistence filter; an aborted pending change is a glitch.
   always_comb begin
      scl_filt_d   = scl_filt_q;
      scl_cnt_d    = scl_cnt_q;
      scl_glitch_s = 1'b0;
      if (scl_sync_q == scl_filt_q) begin
         scl_cnt_d    = 4'd0;
         scl_glitch_s = (scl_cnt_q != 4'd0);
      end else if (scl_cnt_q == CNT_LAST) begin
         scl_filt_d = scl_sync_q;
         scl_cnt_d  = 4'd0;
      end else begin
         scl_cnt_d = scl_cnt_q + 4'd1;
      end
   end

   // SDA persistence filter, same rule as SCL.
   always_comb begin
      sda_filt_d   = sda_filt_q;
      sda_cnt_d    = sda_cnt_q;
      sda_glitch_s = 1'b0;
      if (sda_sync_q == sda_filt_q) begin
         sda_cnt_d    = 4'd0;
         sda_glitch_s = (sda_cnt_q != 4'd0);
      end else if (sda_cnt_q == CNT_LAST) begin
         sda_filt_d = sda_sync_q;
         sda_cnt_d  = 4'd0;
      end else begin
         sda_cnt_d = sda_cnt_q + 4'd1;
      end
   end

   // Glitch counter: clear wins over same-cycle events; sum is one bit wider to catch overflow.
   always_comb begin
      glitch_sum_s = {1'b0, glitch_cnt_q}
                   + {{GCNT_W{1'b0}}, scl_glitch_s}
                   + {{GCNT_W{1'b0}}, sda_glitch_s};
      glitch_cnt_d = glitch_cnt_q;
      if (glitch_clr) begin
         glitch_cnt_d = GCNT_ZERO[GCNT_W-1:0];
      end else if (glitch_sum_s > GCNT_MAX) begin
         glitch_cnt_d = GCNT_MAX[GCNT_W-1:0];
      end else begin
         glitch_cnt_d = glitch_sum_s[GCNT_W-1:0];
      end
   end

   // State registers; reset restores an idle (high) bus with no pending change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_meta_q   <= 1'b1;
         scl_sync_q   <= 1'b1;
         sda_meta_q   <= 1'b1;
         sda_sync_q   <= 1'b1;
         scl_filt_q   <= 1'b1;
         sda_filt_q   <= 1'b1;
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         scl_cnt_q    <= 4'd0;
         sda_cnt_q    <= 4'd0;
         glitch_cnt_q <= GCNT_ZERO[GCNT_W-1:0];
      end else begin
         scl_meta_q   <= scl_meta_d;
         scl_sync_q   <= scl_sync_d;
         sda_meta_q   <= sda_meta_d;
         sda_sync_q   <= sda_sync_d;
         scl_filt_q   <= scl_filt_d;
         sda_filt_q   <= sda_filt_d;
         scl_prev_q   <= scl_prev_d;
         sda_prev_q   <= sda_prev_d;
         scl_cnt_q    <= scl_cnt_d;
         sda_cnt_q    <= sda_cnt_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   // Strobes decode flop outputs only; a simultaneous SCL change masks START/STOP.
   assign scl_filt   = scl_filt_q;
   assign sda_filt   = sda_filt_q;
   assign scl_rise   = scl_filt_q & ~scl_prev_q;
   assign scl_fall   = ~scl_filt_q & scl_prev_q;
   assign start_det  = ~sda_filt_q & sda_prev_q & scl_filt_q & scl_prev_q;
   assign stop_det   = sda_filt_q & ~sda_prev_q & scl_filt_q & scl_prev_q;
   assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Self-checking bench for i2c_line_filter: directed vector table, hand-written
// corner sequences, and random pad noise checked against a sample-history model.
module tb_i2c_line_filter;

   logic       clk;
   logic       rst;
   logic       scl_in;
   logic       sda_in;
   logic       glitch_clr;
   logic       scl_filt;
   logic       sda_filt;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] glitch_cnt;

   int tests = 0;
   int fails = 0;

   i2c_line_filter #(.FILTER_CYCLES(4), .GCNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .glitch_clr (glitch_clr),
      .scl_filt   (scl_filt),
      .sda_filt   (sda_filt),
      .scl_rise   (scl_rise),
      .scl_fall   (scl_fall),
      .start_det  (start_det),
      .stop_det   (stop_det),
      .glitch_cnt (glitch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pads reach the filter two edges late; a line flips once
   // its last four samples all disagree with it; a glitch is a sample that agrees
   // with the line right after one that disagreed without flipping it.
   logic       m_p1_scl, m_p2_scl, m_p1_sda, m_p2_sda;
   logic [3:0] m_h_scl, m_h_sda;
   logic       m_f_scl, m_f_sda, m_fd_scl, m_fd_sda;
   int         m_gcnt;

   task automatic line_upd(input logic s, inout logic [3:0] h, inout logic f, output logic ev);
      ev = (s == f) && (h[0] != f);
      h  = {h[2:0], s};
      if (h == {4{~f}}) f = ~f;
   endtask

   task automatic model_edge();
      logic s_scl, s_sda, ev1, ev2;
      if (rst) begin
         {m_p1_scl, m_p2_scl, m_p1_sda, m_p2_sda} = 4'hF;
         m_h_scl = 4'hF; m_h_sda = 4'hF;
         {m_f_scl, m_f_sda, m_fd_scl, m_fd_sda} = 4'hF;
         m_gcnt = 0;
      end else begin
         s_scl = m_p2_scl; m_p2_scl = m_p1_scl; m_p1_scl = scl_in;
         s_sda = m_p2_sda; m_p2_sda = m_p1_sda; m_p1_sda = sda_in;
         m_fd_scl = m_f_scl;
         m_fd_sda = m_f_sda;
         line_upd(s_scl, m_h_scl, m_f_scl, ev1);
         line_upd(s_sda, m_h_sda, m_f_sda, ev2);
         if (glitch_clr) m_gcnt = 0;
         else begin
            m_gcnt = m_gcnt + int'(ev1) + int'(ev2);
            if (m_gcnt > 255) m_gcnt = 255;
         end
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   // One clock: advance the model on the edge, compare all outputs 1 time unit later.
   task automatic step();
      logic [13:0] act, expv;
      @(posedge clk);
      model_edge();
      #1;
      act  = {glitch_cnt, scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det};
      expv = {m_gcnt[7:0], m_f_scl, m_f_sda,
              m_f_scl & ~m_fd_scl, ~m_f_scl & m_fd_scl,
              ~m_f_sda & m_fd_sda & m_f_scl & m_fd_scl,
              m_f_sda & ~m_fd_sda & m_f_scl & m_fd_scl};
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL model: got %h expected %h at %0t", act, expv, $time);
      end
   endtask

   typedef struct {
      logic scl; logic sda; logic clr; int cycles;
      logic e_scl; logic e_sda; int e_gcnt;
      int e_rise; int e_fall; int e_start; int e_stop;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int n_rise, n_fall, n_start, n_stop, hold_scl, hold_sda;

      tbl[0]  = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1, 0, 0, 0, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1, 0, 0, 0, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 2, 0, 0, 0, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 2, 0, 0, 0, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 4, 0, 0, 0, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0, 4, 0, 0, 1, 0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 4, 0, 0, 0, 1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b1, 4, 0, 1, 0, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 4, 0, 0, 0, 0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b1, 4, 0, 0, 0, 0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 4, 1, 0, 0, 0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 4, 0, 1, 0, 0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 4, 1, 0, 0, 0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0, 0, 0, 0, 0};

      rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1; glitch_clr = 1'b0;
      {m_p1_scl, m_p2_scl, m_p1_sda, m_p2_sda} = 4'hF;
      m_h_scl = 4'hF; m_h_sda = 4'hF;
      {m_f_scl, m_f_sda, m_fd_scl, m_fd_sda} = 4'hF;
      m_gcnt = 0;

      // Reset with idle pads, then 20 quiet cycles.
      repeat (3) step();
      rst = 1'b0;
      chk("rst_scl_filt", int'(scl_filt), 1);
      chk("rst_sda_filt", int'(sda_filt), 1);
      chk("rst_strobes", int'({scl_rise, scl_fall, start_det, stop_det}), 0);
      chk("rst_gcnt", int'(glitch_cnt), 0);
      n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
      repeat (20) begin
         step();
         n_rise += int'(scl_rise); n_fall += int'(scl_fall);
         n_start += int'(start_det); n_stop += int'(stop_det);
      end
      chk("idle_strobes", n_rise + n_fall + n_start + n_stop, 0);

      // Directed vector table.
      for (int i = 0; i < 15; i++) begin
         scl_in = tbl[i].scl; sda_in = tbl[i].sda; glitch_clr = tbl[i].clr;
         n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
         for (int c = 0; c < tbl[i].cycles; c++) begin
            step();
            n_rise += int'(scl_rise); n_fall += int'(scl_fall);
            n_start += int'(start_det); n_stop += int'(stop_det);
         end
         chk($sformatf("tbl%0d_scl_filt", i), int'(scl_filt), int'(tbl[i].e_scl));
         chk($sformatf("tbl%0d_sda_filt", i), int'(sda_filt), int'(tbl[i].e_sda));
         chk($sformatf("tbl%0d_gcnt", i), int'(glitch_cnt), tbl[i].e_gcnt);
         chk($sformatf("tbl%0d_rise", i), n_rise, tbl[i].e_rise);
         chk($sformatf("tbl%0d_fall", i), n_fall, tbl[i].e_fall);
         chk($sformatf("tbl%0d_start", i), n_start, tbl[i].e_start);
         chk($sformatf("tbl%0d_stop", i), n_stop, tbl[i].e_stop);
      end
      glitch_clr = 1'b0;

      // Latency: a held low reaches scl_filt on the 6th edge after the pad change.
      scl_in = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         step();
         chk($sformatf("lat_hold%0d", c), int'(scl_filt), 1);
      end
      step();
      chk("lat_filt6", int'(scl_filt), 0);
      chk("lat_fall6", int'(scl_fall), 1);
      step();
      chk("lat_fall7", int'(scl_fall), 0);
      scl_in = 1'b1;
      repeat (8) step();

      // Saturation: 150 paired glitches -> 300 events.
      repeat (150) begin
         scl_in = 1'b0; sda_in = 1'b0;
         repeat (3) step();
         scl_in = 1'b1; sda_in = 1'b1;
         repeat (5) step();
      end
      chk("sat_gcnt", int'(glitch_cnt), 255);
      scl_in = 1'b0; repeat (3) step();
      scl_in = 1'b1; repeat (5) step();
      chk("sat_hold", int'(glitch_cnt), 255);

      // Clear on the very edge a glitch event is counted.
      scl_in = 1'b0; repeat (3) step();
      scl_in = 1'b1; repeat (2) step();
      glitch_clr = 1'b1;
      step();
      glitch_clr = 1'b0;
      chk("clr_vs_event", int'(glitch_cnt), 0);
      repeat (3) step();
      chk("clr_after", int'(glitch_cnt), 0);
      sda_in = 1'b0; repeat (3) step();
      sda_in = 1'b1; repeat (5) step();
      chk("count_after_clr", int'(glitch_cnt), 1);

      // Reset in the middle of a low bus.
      scl_in = 1'b0; sda_in = 1'b0;
      repeat (8) step();
      chk("pre_rst_scl", int'(scl_filt), 0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_scl_filt", int'(scl_filt), 1);
      chk("midrst_sda_filt", int'(sda_filt), 1);
      chk("midrst_strobes", int'({scl_rise, scl_fall, start_det, stop_det}), 0);
      chk("midrst_gcnt", int'(glitch_cnt), 0);
      scl_in = 1'b1; sda_in = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      n_rise = 0;
      repeat (10) begin
         step();
         n_rise += int'(scl_rise) + int'(scl_fall) + int'(start_det) + int'(stop_det);
      end
      chk("rst_release_strobes", n_rise, 0);

      // Random pad noise against the model.
      hold_scl = 0; hold_sda = 0;
      repeat (3000) begin
         if (hold_scl == 0) begin
            scl_in = 1'($urandom_range(0, 1));
            hold_scl = int'($urandom_range(1, 7));
         end
         if (hold_sda == 0) begin
            sda_in = 1'($urandom_range(0, 1));
            hold_sda = int'($urandom_range(1, 7));
         end
         glitch_clr = ($urandom_range(0, 63) == 0);
         step();
         hold_scl--; hold_sda--;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
